alu_exec_stage: RTL and testbench

//  Registered execute stage wrapping the 64-bit ALU datapath (add/sub/logic/shift units incl. srl64).

---
 rtl/alu_exec_stage.sv | 144 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Registered execute stage around a W-bit ALU (add/sub/logic/shift).
// Holds the architectural condition codes and a retired-op counter.
module alu_exec_stage #(
    parameter int W     = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_set_cc,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic             out_ill,
    output logic [2:0]       cc,
    output logic [CNT_W-1:0] op_count
);

    localparam int SH_W = $clog2(W);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    function automatic logic is_zero(input logic [W-1:0] v);
        return (v == {W{1'b0}});
    endfunction

    logic            accept_s;
    logic            retire_s;
    logic [W-1:0]    res_s;
    logic            of_s;
    logic            ill_s;
    logic            zf_s;
    logic            sf_s;
    logic [SH_W-1:0] shamt_s;

    logic             out_valid_r;
    logic [W-1:0]     out_res_r;
    logic             out_zf_r;
    logic             out_sf_r;
    logic             out_of_r;
    logic             out_ill_r;
    logic [2:0]       cc_r;
    logic [CNT_W-1:0] op_count_r;

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;
    assign retire_s = out_valid_r && out_ready;

    // ALU datapath; illegal opcodes leave the result at zero so zf falls out naturally
    always_comb begin
        res_s   = {W{1'b0}};
        of_s    = 1'b0;
        ill_s   = 1'b0;
        shamt_s = in_b[SH_W-1:0];
        case (in_op)
            OP_ADD: begin
                res_s = in_a + in_b;
                of_s  = (in_a[W-1] == in_b[W-1]) && (res_s[W-1] != in_a[W-1]);
            end
            OP_SUB: begin
                res_s = in_a - in_b;
                of_s  = (in_a[W-1] != in_b[W-1]) && (res_s[W-1] != in_a[W-1]);
            end
            OP_AND:  res_s = in_a & in_b;
            OP_XOR:  res_s = in_a ^ in_b;
            OP_OR:   res_s = in_a | in_b;
            OP_SLL:  res_s = in_a << shamt_s;
            OP_SRL:  res_s = in_a >> shamt_s;
            OP_SRA:  res_s = $unsigned($signed(in_a) >>> shamt_s);
            default: ill_s = 1'b1;
        endcase
        zf_s = is_zero(res_s);
        sf_s = res_s[W-1];
    end

    // Result register: loads on accept, drops valid on retire-only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_res_r   <= {W{1'b0}};
            out_zf_r    <= 1'b0;
            out_sf_r    <= 1'b0;
            out_of_r    <= 1'b0;
            out_ill_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_res_r   <= res_s;
            out_zf_r    <= zf_s;
            out_sf_r    <= sf_s;
            out_of_r    <= of_s;
            out_ill_r   <= ill_s;
        end else if (retire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Condition codes commit at accept time, never for illegal ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_r <= 3'b100;
        end else if (accept_s && in_set_cc && !ill_s) begin
            cc_r <= {zf_s, sf_s, of_s};
        end else begin
            cc_r <= cc_r;
        end
    end

    // Retired-op counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            op_count_r <= op_count_r + CNT_W'(1);
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_zf    = out_zf_r;
    assign out_sf    = out_sf_r;
    assign out_of    = out_of_r;
    assign out_ill   = out_ill_r;
    assign cc        = cc_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage; a second CNT_W=4 instance shares
// all inputs so counter wrap can be observed.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_set_cc;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic        out_zf;
    logic        out_sf;
    logic        out_of;
    logic        out_ill;
    logic [2:0]  cc;
    logic [31:0] op_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [63:0] out_res4;
    logic        out_zf4;
    logic        out_sf4;
    logic        out_of4;
    logic        out_ill4;
    logic [2:0]  cc4;
    logic [3:0]  op_count4;

    int total;
    int bad;

    alu_exec_stage #(.W(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_set_cc(in_set_cc), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .out_ill(out_ill),
        .cc(cc), .op_count(op_count)
    );

    alu_exec_stage #(.W(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_set_cc(in_set_cc), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid4), .out_ready(out_ready), .out_res(out_res4),
        .out_zf(out_zf4), .out_sf(out_sf4), .out_of(out_of4), .out_ill(out_ill4),
        .cc(cc4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic set_cc);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_set_cc = set_cc;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic check_out(input string tag, input logic [63:0] res, input logic [3:0] flags);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_res"}, out_res, res);
        check({tag, "_flags"}, {60'd0, out_zf, out_sf, out_of, out_ill}, {60'd0, flags});
    endtask

    logic [3:0]  bb_op  [4];
    logic [63:0] bb_a   [4];
    logic [63:0] bb_b   [4];
    logic [63:0] bb_exp [4];

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_set_cc = 1'b0;
        in_a      = 64'd0;
        in_b      = 64'd0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_res", out_res, 64'd0);
        check("rst_flags", {60'd0, out_zf, out_sf, out_of, out_ill}, 64'd0);
        check("rst_cc", {61'd0, cc}, 64'd4);
        check("rst_cnt", {32'd0, op_count}, 64'd0);
        rst = 1'b0;
        step();

        // basic add, one-cycle latency, retire counts
        issue(4'd0, 64'd5, 64'd7, 1'b1);
        check_out("add", 64'd12, 4'b0000);
        check("add_cc", {61'd0, cc}, 64'd0);
        check("add_cnt_pre", {32'd0, op_count}, 64'd0);
        idle();
        check("add_cnt", {32'd0, op_count}, 64'd1);
        check("add_drop_valid", {63'd0, out_valid}, 64'd0);
        check("add_hold_res", out_res, 64'd12);

        // overflow and zero result
        issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check_out("add_ovf", 64'h8000_0000_0000_0000, 4'b0110);
        check("add_ovf_cc", {61'd0, cc}, 64'd3);
        issue(4'd1, 64'd3, 64'd3, 1'b1);
        check_out("sub_zero", 64'd0, 4'b1000);
        check("sub_zero_cc", {61'd0, cc}, 64'd4);
        issue(4'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        check_out("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 4'b0010);
        check("sub_ovf_cc_kept", {61'd0, cc}, 64'd4);

        // shifts and logic
        issue(4'd6, 64'h8000_0000_0000_00F0, 64'd4, 1'b0);
        check_out("srl", 64'h0800_0000_0000_000F, 4'b0000);
        issue(4'd7, 64'h8000_0000_0000_00F0, 64'd4, 1'b0);
        check_out("sra", 64'hF800_0000_0000_000F, 4'b0100);
        issue(4'd5, 64'h8000_0000_0000_00F0, 64'h44, 1'b0);
        check_out("sll", 64'h0000_0000_0000_0F00, 4'b0000);
        issue(4'd6, 64'h8000_0000_0000_00F0, 64'h40, 1'b0);
        check_out("srl0", 64'h8000_0000_0000_00F0, 4'b0100);
        issue(4'd7, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
        check_out("sra63", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
        issue(4'd2, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 1'b0);
        check_out("and", 64'h0F00_0F00_1234_0000, 4'b0000);
        issue(4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        check_out("xor", 64'd0, 4'b1000);
        issue(4'd4, 64'h00F0, 64'h0F00, 1'b0);
        check_out("or", 64'h0FF0, 4'b0000);
        check("shift_cc_kept", {61'd0, cc}, 64'd4);
        idle();
        check("logic_cnt", {32'd0, op_count}, 64'd12);

        // backpressure: stall three cycles, then back-to-back flow
        out_ready = 1'b0;
        issue(4'd0, 64'd10, 64'd20, 1'b1);
        check_out("stall_first", 64'd30, 4'b0000);
        check("stall_first_cc", {61'd0, cc}, 64'd0);
        in_valid  = 1'b1;
        in_op     = 4'd1;
        in_a      = 64'd100;
        in_b      = 64'd100;
        in_set_cc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", {63'd0, in_ready}, 64'd0);
            step();
            check("stall_res", out_res, 64'd30);
            check("stall_cc", {61'd0, cc}, 64'd0);
            check("stall_cnt", {32'd0, op_count}, 64'd12);
        end
        out_ready = 1'b1;
        bb_op[0] = 4'd1; bb_a[0] = 64'd100;  bb_b[0] = 64'd1; bb_exp[0] = 64'd99;
        bb_op[1] = 4'd0; bb_a[1] = 64'd1;    bb_b[1] = 64'd1; bb_exp[1] = 64'd2;
        bb_op[2] = 4'd3; bb_a[2] = 64'hF;    bb_b[2] = 64'd3; bb_exp[2] = 64'hC;
        bb_op[3] = 4'd4; bb_a[3] = 64'h10;   bb_b[3] = 64'd1; bb_exp[3] = 64'h11;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_op     = bb_op[i];
            in_a      = bb_a[i];
            in_b      = bb_b[i];
            in_set_cc = 1'b0;
            #1;
            check("flow_ready", {63'd0, in_ready}, 64'd1);
            step();
            check("flow_res", out_res, bb_exp[i]);
            check("flow_valid", {63'd0, out_valid}, 64'd1);
        end
        check("flow_cnt_mid", {32'd0, op_count}, 64'd16);
        idle();
        check("flow_cnt", {32'd0, op_count}, 64'd17);
        check("flow_cc", {61'd0, cc}, 64'd0);

        // illegal opcode
        issue(4'hA, 64'd55, 64'd66, 1'b1);
        check_out("ill", 64'd0, 4'b1001);
        check("ill_cc", {61'd0, cc}, 64'd0);
        idle();
        check("ill_cnt", {32'd0, op_count}, 64'd18);

        // reset during a stall takes effect without a clock edge
        out_ready = 1'b0;
        issue(4'd0, 64'd1, 64'd1, 1'b1);
        check_out("pre_rst", 64'd2, 4'b0000);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_cc", {61'd0, cc}, 64'd4);
        check("mid_rst_cnt", {32'd0, op_count}, 64'd0);
        check("mid_rst_res", out_res, 64'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();

        // counter wrap on the narrow instance
        for (int i = 0; i < 17; i++) begin
            in_valid  = 1'b1;
            in_op     = 4'd0;
            in_a      = 64'(i);
            in_b      = 64'(i);
            in_set_cc = 1'b0;
            step();
        end
        idle();
        check("wrap_cnt32", {32'd0, op_count}, 64'd17);
        check("wrap_cnt4", {60'd0, op_count4}, 64'd1);
        check("wrap_res4", out_res4, 64'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
